parity_checker: RTL

PARITY_CHECKER -- requirements
Module: parity_checker

---
 rtl/parity_checker_pkg.sv | 23 ++
 rtl/bit_timer.sv | 42 ++++
 rtl/parity_checker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/parity_checker_pkg.sv
`default_nettype none
// ============================================================================
// parity_checker_pkg : FSM state encoding and default display patterns
// Revision 1.0
// ============================================================================
package parity_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [7:0] c_LED_OK   = 8'b00000011;
  localparam logic [7:0] c_LED_ERR  = 8'b00110001;
  localparam logic [7:0] c_LED_IDLE = 8'b11111101;
  localparam logic [3:0] c_AN_SEL   = 4'b1101;

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// bit_timer : loadable down-counter, strobes at half-bit then every full bit
// Revision 1.0
// ============================================================================
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_start,
  input  logic i_clear,
  output logic o_tick
);

  localparam int c_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_W-1:0] c_HALF = c_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_W-1:0] c_FULL = c_W'(CLKS_PER_BIT - 1);

  logic [c_W-1:0] r_cnt;
  logic           r_run;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_clear) begin
      r_run <= 1'b0;
    end else if (i_start) begin
      r_cnt <= c_HALF;
      r_run <= 1'b1;
    end else if (r_run) begin
      // After each strobe the next sample lands one full bit later.
      r_cnt <= (r_cnt == '0) ? c_FULL : r_cnt - 1'b1;
    end
  end

  assign o_tick = r_run && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/parity_checker.sv
`default_nettype none
// ============================================================================
// parity_checker : serial frame receiver with even-parity and stop-bit checks
// Revision 1.0
// ============================================================================
module parity_checker
  import parity_checker_pkg::*;
#(
  parameter int                N_SW         = 8,
  parameter int                CLKS_PER_BIT = 16,
  parameter int                N_LED        = 8,
  parameter int                N_LED_AN     = 4,
  parameter logic [N_LED-1:0]  LED_OK       = c_LED_OK,
  parameter logic [N_LED-1:0]  LED_ERR      = c_LED_ERR,
  parameter logic [N_LED-1:0]  LED_IDLE     = c_LED_IDLE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  output logic [N_SW-1:0]     data_o,
  output logic                valid_o,
  output logic                parity_err_o,
  output logic                frame_err_o,
  output logic [N_LED-1:0]    led_o,
  output logic [N_LED_AN-1:0] led_an_o
);

  localparam int c_CW = $clog2(N_SW + 1);

  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [c_CW-1:0]   r_bitcnt;
  logic [N_SW-1:0]   r_shift;
  logic              r_par;
  logic [N_SW-1:0]   r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic [N_LED-1:0]  r_led;

  logic w_rx;
  logic w_tick;
  logic w_start;
  logic w_clear;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx    = r_sync2;
  assign w_start = (r_state == S_IDLE) && !w_rx;
  // Stop the timer on a rejected start glitch and after the stop sample.
  assign w_clear = w_tick && (((r_state == S_START) && w_rx) || (r_state == S_STOP));

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_start (w_start),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_led    <= LED_IDLE;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          r_bitcnt <= '0;
          r_par    <= 1'b0;
          if (w_tick) begin
            r_state <= w_rx ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {w_rx, r_shift[N_SW-1:1]};
            r_par   <= r_par ^ w_rx;
            if (r_bitcnt == c_CW'(N_SW - 1)) begin
              r_state <= S_PARITY;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par   <= r_par ^ w_rx;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_state <= S_IDLE;
            r_data  <= r_shift;
            r_valid <= 1'b1;
            r_perr  <= r_par;
            r_ferr  <= !w_rx;
            r_led   <= (r_par || !w_rx) ? LED_ERR : LED_OK;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign parity_err_o = r_perr;
  assign frame_err_o  = r_ferr;
  assign led_o        = r_led;
  assign led_an_o     = N_LED_AN'(c_AN_SEL);

endmodule

`default_nettype wire
